// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: oversamples the MCU SPI pins in the clk domain and turns frames into
// a strobe/start/byte stream. The consumer's response byte is shifted back out on MISO.
module mcu_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       byte_strobe,
  output logic       byte_start,
  output logic [7:0] byte_data,
  input  logic [7:0] resp_data,
  output logic       frame_active,
  output logic [7:0] byte_count
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ARMED_WAIT = 2'd1,
    ST_ACTIVE     = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] csn_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   csn_d_r;
  logic                   sclk_d_r;
  logic [2:0]             bit_cnt_r;
  logic [6:0]             rx_r;
  logic [7:0]             tx_r;
  logic                   first_r;
  logic [7:0]             byte_count_r;
  logic [7:0]             byte_data_r;
  logic                   byte_strobe_r;
  logic                   byte_start_r;
  logic                   spi_miso_r;

  logic       csn_s;
  logic       sclk_s;
  logic       mosi_s;
  logic       csn_fall_s;
  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic [7:0] rx_nxt_s;

  // Synchronizers run through reset so a chip select held low is seen as steady, not as a fresh fall.
  always_ff @(posedge clk) begin
    csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], spi_csn};
    sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
    csn_d_r     <= csn_s;
    sclk_d_r    <= sclk_s;
  end

  assign csn_s       = csn_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign csn_fall_s  = csn_d_r & ~csn_s;
  assign sclk_rise_s = ~sclk_d_r & sclk_s & ~csn_s;
  assign sclk_fall_s = sclk_d_r & ~sclk_s & ~csn_s;
  assign rx_nxt_s    = {rx_r, mosi_s};

  // Frame FSM with receive/transmit shifters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= csn_s ? ST_IDLE : ST_ARMED_WAIT;
      bit_cnt_r     <= 3'd0;
      rx_r          <= 7'd0;
      tx_r          <= 8'h00;
      first_r       <= 1'b0;
      byte_count_r  <= 8'd0;
      byte_data_r   <= 8'h00;
      byte_strobe_r <= 1'b0;
      byte_start_r  <= 1'b0;
      spi_miso_r    <= 1'b0;
    end else begin
      byte_strobe_r <= 1'b0;
      byte_start_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          spi_miso_r <= 1'b0;
          if (csn_fall_s) begin
            state_r      <= ST_ACTIVE;
            bit_cnt_r    <= 3'd0;
            byte_count_r <= 8'd0;
            first_r      <= 1'b1;
            tx_r         <= 8'h00;
          end
        end
        ST_ARMED_WAIT: begin
          spi_miso_r <= 1'b0;
          if (csn_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (csn_s) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            spi_miso_r <= 1'b0;
          end else begin
            if (sclk_rise_s) begin
              rx_r      <= rx_nxt_s[6:0];
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                byte_data_r   <= rx_nxt_s;
                byte_strobe_r <= 1'b1;
                byte_start_r  <= first_r;
                first_r       <= 1'b0;
                if (byte_count_r != 8'hFF) begin
                  byte_count_r <= byte_count_r + 8'd1;
                end
              end
            end
            // MISO follows the next tx value so it moves one clk after the fall is seen.
            if (sclk_fall_s) begin
              if (bit_cnt_r == 3'd0) begin
                tx_r       <= resp_data;
                spi_miso_r <= resp_data[7];
              end else begin
                tx_r       <= {tx_r[6:0], 1'b0};
                spi_miso_r <= tx_r[6];
              end
            end else begin
              spi_miso_r <= tx_r[7];
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          spi_miso_r <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso     = spi_miso_r;
  assign byte_strobe  = byte_strobe_r;
  assign byte_start   = byte_start_r;
  assign byte_data    = byte_data_r;
  assign frame_active = (state_r == ST_ACTIVE);
  assign byte_count   = byte_count_r;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: a bit-banged SPI master, a consumer response table
// and a strobe recorder, with hand-computed expectations.
module tb_mcu_spi_target;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_csn;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       byte_strobe;
  logic       byte_start;
  logic [7:0] byte_data;
  logic [7:0] resp_data = 8'h00;
  logic       frame_active;
  logic [7:0] byte_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sd [512];
  logic       ss [512];
  int         n_strobe = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] resp_tab [8];
  int         resp_len = 0;
  int         resp_base = 0;

  mcu_spi_target #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .byte_strobe(byte_strobe), .byte_start(byte_start),
    .byte_data(byte_data), .resp_data(resp_data), .frame_active(frame_active),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe recorder and consumer: answers each strobe with the next table entry within one cycle.
  always @(negedge clk) begin
    int k;
    if (byte_strobe) begin
      check_eq("no_double_strobe", {31'd0, prev_strobe}, 32'd0);
      if (n_strobe < 512) begin
        sd[n_strobe] = byte_data;
        ss[n_strobe] = byte_start;
      end
      k = n_strobe - resp_base;
      resp_data = (k >= 0 && k < resp_len) ? resp_tab[k] : 8'h00;
      n_strobe++;
    end
    prev_strobe = byte_strobe;
  end

  task automatic spi_bits(input logic [7:0] tx_b, input int nbits, input int half,
                          output logic [7:0] rx_b);
    rx_b = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx_b[i];
      repeat (half) @(negedge clk);
      rx_b = {rx_b[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_csn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] mb [4];
    logic [7:0] wr [4];
    logic [7:0] bv;
    int base;
    int starts;

    reset = 1'b1; spi_csn = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("rst_strobe", {31'd0, byte_strobe}, 32'd0);
    check_eq("rst_start", {31'd0, byte_start}, 32'd0);
    check_eq("rst_data", {24'd0, byte_data}, 32'h00);
    check_eq("rst_active", {31'd0, frame_active}, 32'd0);
    check_eq("rst_count", {24'd0, byte_count}, 32'd0);

    // Status read: MISO carries 0x00 then the responses to the preceding strobes.
    base = n_strobe;
    resp_tab[0] = 8'h5C; resp_tab[1] = 8'h42; resp_tab[2] = 8'h00;
    resp_len = 3; resp_base = base;
    frame_begin();
    check_eq("stat_active", {31'd0, frame_active}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      spi_bits(8'h00, 8, 8, rb);
      mb[i] = rb;
    end
    repeat (4) @(negedge clk);
    check_eq("stat_count", {24'd0, byte_count}, 32'd4);
    frame_end();
    check_eq("stat_miso0", {24'd0, mb[0]}, 32'h00);
    check_eq("stat_miso1", {24'd0, mb[1]}, 32'h5C);
    check_eq("stat_miso2", {24'd0, mb[2]}, 32'h42);
    check_eq("stat_miso3", {24'd0, mb[3]}, 32'h00);
    check_eq("stat_nstrobe", n_strobe - base, 32'd4);
    starts = 0;
    for (int i = 0; i < 4; i++) starts += int'(ss[base + i]);
    check_eq("stat_nstart", starts, 32'd1);
    check_eq("stat_start0", {31'd0, ss[base]}, 32'd1);
    check_eq("stat_inactive", {31'd0, frame_active}, 32'd0);

    // Command write at SCK = clk/8.
    base = n_strobe; resp_len = 0; resp_base = base;
    wr[0] = 8'h02; wr[1] = 8'hFF; wr[2] = 8'h10; wr[3] = 8'h01;
    frame_begin();
    for (int i = 0; i < 4; i++) spi_bits(wr[i], 8, 4, rb);
    frame_end();
    check_eq("cmd_nstrobe", n_strobe - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("cmd_data%0d", i), {24'd0, sd[base + i]}, {24'd0, wr[i]});
      check_eq($sformatf("cmd_start%0d", i), {31'd0, ss[base + i]}, (i == 0) ? 32'd1 : 32'd0);
    end
    check_eq("cmd_held", {24'd0, byte_data}, 32'h01);

    // Abort after 5 bits of byte 2; the queued response must not leak into the next frame.
    base = n_strobe; resp_tab[0] = 8'h77; resp_len = 1; resp_base = base;
    frame_begin();
    spi_bits(8'hA5, 8, 4, rb);
    spi_bits(8'hC3, 5, 4, rb);
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    repeat (SYNC) @(negedge clk);
    check_eq("abort_still_active", {31'd0, frame_active}, 32'd1);
    @(negedge clk);
    check_eq("abort_inactive", {31'd0, frame_active}, 32'd0);
    repeat (8) @(negedge clk);
    check_eq("abort_nstrobe", n_strobe - base, 32'd1);
    check_eq("abort_data", {24'd0, sd[base]}, 32'hA5);
    frame_begin();
    spi_bits(8'h3C, 8, 4, rb);
    frame_end();
    check_eq("abort_next_miso", {24'd0, rb}, 32'h00);
    check_eq("abort_next_n", n_strobe - base, 32'd2);
    check_eq("abort_next_start", {31'd0, ss[base + 1]}, 32'd1);
    check_eq("abort_next_data", {24'd0, sd[base + 1]}, 32'h3C);

    // Reset mid-frame with CSN held low: the cut frame is never resumed.
    base = n_strobe; resp_len = 0; resp_base = base;
    frame_begin();
    spi_bits(8'h11, 8, 4, rb);
    spi_bits(8'hFF, 3, 4, rb);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rmid_data", {24'd0, byte_data}, 32'h00);
    check_eq("rmid_count", {24'd0, byte_count}, 32'd0);
    check_eq("rmid_active", {31'd0, frame_active}, 32'd0);
    check_eq("rmid_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("rmid_strobe", {31'd0, byte_strobe}, 32'd0);
    spi_bits(8'hAB, 8, 4, rb);
    spi_bits(8'hAB, 8, 4, rb);
    repeat (4) @(negedge clk);
    check_eq("rmid_nostrobe", n_strobe - base, 32'd1);
    check_eq("rmid_still_idle", {31'd0, frame_active}, 32'd0);
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
    frame_begin();
    spi_bits(8'h99, 8, 4, rb);
    frame_end();
    check_eq("rmid_refall_n", n_strobe - base, 32'd2);
    check_eq("rmid_refall_data", {24'd0, sd[base + 1]}, 32'h99);
    check_eq("rmid_refall_start", {31'd0, ss[base + 1]}, 32'd1);

    // Back-to-back frames separated by one SCK period of CSN high.
    base = n_strobe;
    frame_begin();
    spi_bits(8'h81, 8, 4, rb);
    spi_bits(8'h42, 8, 4, rb);
    repeat (2) @(negedge clk);
    check_eq("b2b_count_a", {24'd0, byte_count}, 32'd2);
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("b2b_count_restart", {24'd0, byte_count}, 32'd0);
    spi_bits(8'h18, 8, 4, rb);
    repeat (2) @(negedge clk);
    check_eq("b2b_count_b", {24'd0, byte_count}, 32'd1);
    frame_end();
    check_eq("b2b_n", n_strobe - base, 32'd3);
    check_eq("b2b_d0", {24'd0, sd[base]}, 32'h81);
    check_eq("b2b_d1", {24'd0, sd[base + 1]}, 32'h42);
    check_eq("b2b_d2", {24'd0, sd[base + 2]}, 32'h18);
    check_eq("b2b_s1", {31'd0, ss[base + 1]}, 32'd0);
    check_eq("b2b_s2", {31'd0, ss[base + 2]}, 32'd1);

    // Saturation: 300-byte frame.
    base = n_strobe;
    frame_begin();
    for (int i = 0; i < 300; i++) begin
      bv = 8'(i);
      spi_bits(bv, 8, 4, rb);
      if (i == 253) check_eq("sat_count254", {24'd0, byte_count}, 32'd254);
      if (i == 254) check_eq("sat_count255", {24'd0, byte_count}, 32'd255);
      if (i == 299) check_eq("sat_count300", {24'd0, byte_count}, 32'd255);
    end
    frame_end();
    check_eq("sat_n", n_strobe - base, 32'd300);
    check_eq("sat_last_data", {24'd0, sd[base + 299]}, 32'h2B);
    check_eq("sat_last_start", {31'd0, ss[base + 299]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mcu_spi_target.md
# mcu_spi_target

SPI target (mode 0, MSB first) that terminates the MCU link in the FPGA and converts SPI frames into the byte-stream handshake consumed by the system-control and other MCU-facing blocks (`strobe`/`start`/byte). It returns each block's response byte to the MCU over MISO. It oversamples the SPI pins in the `clk` domain, so no SPI clock enters the fabric.

## Interface
- SYNC_STAGES, 2, synchronizer flops on `spi_csn`/`spi_sclk`/`spi_mosi` (legal 2..3)
- clk  in  1  system clock; must be ≥ 8× SCK frequency
- reset  in  1  synchronous, active-high
- spi_csn  in  1  chip select, active low, asynchronous
- spi_sclk  in  1  SPI clock, idle low, asynchronous
- spi_mosi  in  1  MCU→FPGA data, asynchronous
- spi_miso  out  1  FPGA→MCU data, registered
- byte_strobe  out  1  one-cycle pulse: `byte_data` valid
- byte_start  out  1  qualifies `byte_strobe`: first byte of the frame (command byte)
- byte_data  out  8  received byte, held until the next strobe
- resp_data  in  8  response byte from the consumer, sampled as described below
- frame_active  out  1  high while a valid frame is in progress
- byte_count  out  8  bytes completed in the current frame, saturating at 255

## Operation
- Sync stage: each SPI input passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - CSN fall: `csn_s` goes 1→0.
  - SCK rise: `sclk_s` goes 0→1 while `csn_s`=0.
  - SCK fall: `sclk_s` goes 1→0 while `csn_s`=0.
- FSM states: IDLE, ARMED_WAIT, ACTIVE.
  - IDLE→ACTIVE on CSN fall. Actions: clear bit counter, `byte_count`=0, `first`=1, tx shift register=0x00.
  - ACTIVE→IDLE on `csn_s`=1. Any partial byte is discarded; no strobe is issued for it.
  - After reset the FSM enters ARMED_WAIT if `csn_s`=0, otherwise IDLE. ARMED_WAIT→IDLE when `csn_s`=1. A frame cut by reset is never resumed.
- Receive (ACTIVE): on each SCK rise, rx shift = {rx[6:0], mosi_s} and bit counter += 1 (3-bit, wraps).
  - On the 8th rise (counter 7→0), in the next cycle: `byte_data`=rx byte, `byte_strobe`=1, `byte_start`=`first`, then `first`=0 and `byte_count`+=1 (saturating).
- Transmit (ACTIVE):
  - `spi_miso` = tx[7] at all times in ACTIVE, and 0 outside ACTIVE.
  - On SCK fall with bit counter ≠ 0: tx = {tx[6:0], 0}.
  - On SCK fall with bit counter = 0 (8th fall of a byte): tx = `resp_data`.
  - The first byte of a frame therefore returns 0x00. Byte n (n≥2) returns `resp_data` as sampled at the 8th fall of byte n−1.
- Consumer contract: the consumer updates `resp_data` no later than 1 cycle after `byte_strobe`.
- `frame_active` = (state == ACTIVE).

## Timing
- Reset values: `spi_miso`=0, `byte_strobe`=0, `byte_start`=0, `byte_data`=0x00, `frame_active`=0, `byte_count`=0, tx=0x00, bit counter=0.
- Pin-to-edge-detect latency: SYNC_STAGES+1 clk cycles.
- `byte_strobe` rises 1 clk after the 8th SCK rise is detected, i.e. SYNC_STAGES+2 cycles after the pin edge.
- `resp_data` setup: with clk ≥ 8× SCK, the 8th fall is detected at least 4 clk after `byte_strobe`. Sampling at the fall therefore captures the response to the just-strobed byte.
- `spi_miso` changes 1 clk after fall detection. That is SYNC_STAGES+2 clk after the pin edge, within a half SCK period when clk ≥ 8× SCK.
- CSN fall and SCK rise detected in the same cycle: CSN fall has priority; that SCK rise is ignored.
- CSN rise coinciding with the 8th SCK rise: no strobe.
- `byte_strobe` is never asserted for two consecutive cycles.

## Test plan
- Status read: frame of 4 bytes {0x00,0x00,0x00,0x00}, consumer model returns 0x5C,0x42,0x00 after the strobes → MISO bytes 0x00,0x5C,0x42,0x00; exactly one strobe with `byte_start`=1 (first byte); `byte_count` ends at 4.
- Command write: frame {0x02,0xFF,0x10,0x01} at SCK=clk/8 → strobes carry 0x02 (start=1), 0xFF, 0x10, 0x01 (start=0).
- Abort: CSN rises after 5 bits of byte 2 → exactly one strobe; `frame_active`=0 SYNC_STAGES+1 cycles later. The next frame's first byte has `byte_start`=1 and MISO 0x00.
- Reset mid-frame: reset asserted during byte 2 with CSN held low → no strobes until CSN goes high and falls again; all outputs at their reset values.
- Back-to-back frames with one SCK period of CSN high: both frames decode correctly and `byte_count` restarts at 0.
- Saturation: 300-byte frame → 300 strobes; `byte_count`=255 from byte 255 onward.
